// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder/subtractor whose carry chain is cut into SEG-bit segments.
//   Each segment gets one register rank, so the pipeline depth is
//   STAGES = WIDTH/SEG cycles. Valid/ready handshaking uses one global stall:
//   every rank advances together, and all ranks hold while the result rank is
//   full and the consumer is not ready.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set a/b/sub is valid
//   in_ready   block accepts an operand set this cycle (combinational from out_ready)
//   a, b       operands, WIDTH bits
//   sub        0: a+b, 1: a-b
//   out_valid  sum/ovf hold a valid result
//   out_ready  consumer accepts the result this cycle
//   sum        {carry_out, result[WIDTH-1:0]}
//   ovf        two's-complement signed overflow of result
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  // Inter-stage ranks exist only between stages; keep at least one entry so
  // the arrays stay legal for a single-stage build.
  localparam int PL     = (STAGES > 1) ? STAGES - 1 : 1;

  if ((WIDTH % SEG) != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
  end

  // Inter-stage registers: rank k holds the outputs of stage k (k < LAST).
  // Operands travel whole; stage k only consumes segment k, so the segments
  // above k form the skewed operand and the segments below k are already
  // folded into res_r.
  logic             v_r   [PL];
  logic [WIDTH-1:0] a_r   [PL];
  logic [WIDTH-1:0] b_r   [PL];
  logic [WIDTH-1:0] res_r [PL];
  logic             cy_r  [PL];

  // Final rank drives the outputs directly.
  logic             out_valid_r;
  logic [WIDTH:0]   sum_r;
  logic             ovf_r;

  // Stage inputs and per-stage arithmetic.
  logic             st_v_s     [STAGES];
  logic [WIDTH-1:0] st_a_s     [STAGES];
  logic [WIDTH-1:0] st_b_s     [STAGES];
  logic [WIDTH-1:0] st_res_s   [STAGES];
  logic             st_c_s     [STAGES];
  logic [SEG:0]     seg_sum_s  [STAGES];
  logic [WIDTH-1:0] nxt_res_s  [STAGES];
  logic             ovf_nxt_s;
  logic             advance_s;

  // Global stall: everything moves unless a finished result is blocked.
  assign advance_s = !out_valid_r || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign ovf       = ovf_r;

  // Stage input selection: stage 0 from the ports (B inverted and carry-in
  // set for subtraction), later stages from the previous rank.
  always_comb begin
    st_v_s[0]   = in_valid;
    st_a_s[0]   = a;
    st_b_s[0]   = sub ? ~b : b;
    st_c_s[0]   = sub;
    st_res_s[0] = {WIDTH{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      st_v_s[k]   = v_r[k-1];
      st_a_s[k]   = a_r[k-1];
      st_b_s[k]   = b_r[k-1];
      st_c_s[k]   = cy_r[k-1];
      st_res_s[k] = res_r[k-1];
    end
  end

  // Segment adders: stage k adds segment k and merges it into the result.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_sum_s[k] = {1'b0, SEG'(st_a_s[k] >> (k * SEG))}
                   + {1'b0, SEG'(st_b_s[k] >> (k * SEG))}
                   + {{SEG{1'b0}}, st_c_s[k]};
      nxt_res_s[k] = st_res_s[k] | (WIDTH'(seg_sum_s[k][SEG-1:0]) << (k * SEG));
    end
    // Signed overflow: operands agree in sign but the result does not.
    ovf_nxt_s = (st_a_s[LAST][WIDTH-1] == st_b_s[LAST][WIDTH-1]) &&
                (nxt_res_s[LAST][WIDTH-1] != st_a_s[LAST][WIDTH-1]);
  end

  // Pipeline ranks: clear on reset, shift together on advance, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PL; k++) begin
        v_r[k]   <= 1'b0;
        a_r[k]   <= {WIDTH{1'b0}};
        b_r[k]   <= {WIDTH{1'b0}};
        res_r[k] <= {WIDTH{1'b0}};
        cy_r[k]  <= 1'b0;
      end
      out_valid_r <= 1'b0;
      sum_r       <= {(WIDTH + 1){1'b0}};
      ovf_r       <= 1'b0;
    end else if (advance_s) begin
      // Bubbles shift like data; only the valid bit marks them.
      for (int k = 0; k < LAST; k++) begin
        v_r[k]   <= st_v_s[k];
        a_r[k]   <= st_a_s[k];
        b_r[k]   <= st_b_s[k];
        res_r[k] <= nxt_res_s[k];
        cy_r[k]  <= seg_sum_s[k][SEG];
      end
      out_valid_r <= st_v_s[LAST];
      sum_r       <= {seg_sum_s[LAST][SEG], nxt_res_s[LAST]};
      ovf_r       <= ovf_nxt_s;
    end else begin
      out_valid_r <= out_valid_r;
      sum_r       <= sum_r;
      ovf_r       <= ovf_r;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: an 8-bit/4-bit-segment instance
// (latency 2) and a 32-bit/8-bit-segment instance (latency 4). Expected
// results come from constants or an integer reference model and travel
// through per-instance scoreboard queues.
module tb_pipelined_adder;

  localparam int LAT8 = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv8, ir8, ov8, or8, sub8, ovf8;
  logic [7:0]  a8, b8;
  logic [8:0]  sum8;

  logic        iv32, ir32, ov32, or32, sub32, ovf32;
  logic [31:0] a32, b32;
  logic [32:0] sum32;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboards: {ovf, sum[32:0]}.
  logic [33:0] q8[$];
  logic [33:0] q32[$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .SEG(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8), .ovf(ovf8)
  );

  pipelined_adder #(.WIDTH(32), .SEG(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32), .ovf(ovf32)
  );

  // Reference model in plain integer arithmetic: unsigned result and carry
  // (no-borrow for subtraction), signed overflow from the true signed result.
  function automatic logic [33:0] ref_model(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic s);
    longint mask, ux, uy, sx, sy, r, res, lim;
    logic   cy, ov;
    logic [32:0] sv;
    mask = (longint'(1) << w) - longint'(1);
    lim  = longint'(1) << (w - 1);
    ux   = longint'(x) & mask;
    uy   = longint'(y) & mask;
    sx   = (ux >= lim) ? ux - (longint'(1) << w) : ux;
    sy   = (uy >= lim) ? uy - (longint'(1) << w) : uy;
    if (s) begin
      res = (ux - uy) & mask;
      cy  = (ux >= uy);
      r   = sx - sy;
    end else begin
      res = (ux + uy) & mask;
      cy  = ((ux + uy) > mask);
      r   = sx + sy;
    end
    ov = (r >= lim) || (r < -lim);
    sv = 33'(res) | ({32'd0, cy} << w);
    return {ov, sv};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0; or8 = 1'b1;
    iv32 = 1'b0; a32 = 32'd0; b32 = 32'd0; sub32 = 1'b0; or32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (ov8 !== 1'b0) $display("FAIL reset_out_valid cycle %0d: got %b want 0", i, ov8);
      else n_pass++;
      n_checks++;
      if (sum8 !== 9'h000) $display("FAIL reset_sum cycle %0d: got %h want 000", i, sum8);
      else n_pass++;
      n_checks++;
      if (ovf8 !== 1'b0) $display("FAIL reset_ovf cycle %0d: got %b want 0", i, ovf8);
      else n_pass++;
      n_checks++;
      if (ir8 !== 1'b1) $display("FAIL reset_in_ready cycle %0d: got %b want 1", i, ir8);
      else n_pass++;
      n_checks++;
      if ((ov32 !== 1'b0) || (sum32 !== 33'd0)) $display("FAIL reset_dut32 cycle %0d: valid %b sum %h want 0/0", i, ov32, sum32);
      else n_pass++;
      // Two reset edges, then idle.
      if (i == 1) rst = 1'b0;
    end
  endtask

  // Three back-to-back operations; results must arrive on consecutive cycles
  // exactly LAT8 cycles after their accept.
  task automatic test_arith_seq(input string name, input logic s,
                                input logic [2:0][7:0] av, input logic [2:0][7:0] bv,
                                input logic [2:0][8:0] ev, input logic [2:0] eo);
    int sent = 0;
    int got  = 0;
    int acc0 = -100;
    for (int it = 0; it < 10; it++) begin
      @(negedge clk);
      or8 = 1'b1;
      if (sent < 3) begin
        iv8 = 1'b1; a8 = av[2-sent]; b8 = bv[2-sent]; sub8 = s;
      end else begin
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0;
      end
      #1;
      if (ov8 && or8) begin
        n_checks++;
        if (got >= 3)
          $display("FAIL %s extra result: got sum %h ovf %b, want none", name, sum8, ovf8);
        else if ((sum8 !== ev[2-got]) || (ovf8 !== eo[2-got]) || (it != acc0 + LAT8 + got))
          $display("FAIL %s op %0d: got sum %h ovf %b cycle %0d, want sum %h ovf %b cycle %0d",
                   name, got, sum8, ovf8, it, ev[2-got], eo[2-got], acc0 + LAT8 + got);
        else n_pass++;
        got++;
      end
      if (iv8 && ir8) begin
        if (sent == 0) acc0 = it;
        sent++;
      end
    end
    n_checks++;
    if (got != 3) $display("FAIL %s result count: got %0d want 3", name, got);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0][7:0] av = {8'h11, 8'hF0, 8'h40, 8'hAA};
    logic [3:0][7:0] bv = {8'h22, 8'h20, 8'h40, 8'h0F};
    logic [3:0]      sv = 4'b0001;
    logic [3:0][8:0] ev = {9'h033, 9'h110, 9'h080, 9'h19B};
    logic [3:0]      eo = 4'b0010;
    logic [33:0] exp_v;
    logic [8:0]  held = 9'h000;
    logic        seen = 1'b0;
    int sent = 0, got = 0, stall = 0;
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      if (sent < 4) begin
        iv8 = 1'b1; a8 = av[3-sent]; b8 = bv[3-sent]; sub8 = sv[3-sent];
      end else begin
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0;
      end
      #1;
      if (ov8 && !seen) begin
        seen = 1'b1; stall = 3; held = sum8;
      end
      or8 = (stall == 0);
      #1;
      if (stall > 0) begin
        n_checks++;
        if (ir8 !== 1'b0) $display("FAIL bp_in_ready stall: got %b want 0", ir8);
        else n_pass++;
        n_checks++;
        if ((sum8 !== held) || (ov8 !== 1'b1)) $display("FAIL bp_hold: got sum %h valid %b want sum %h valid 1", sum8, ov8, held);
        else n_pass++;
        stall--;
      end
      if (ov8 && or8) begin
        n_checks++;
        if (q8.size() == 0) $display("FAIL bp_extra: got sum %h, want no result", sum8);
        else begin
          exp_v = q8.pop_front();
          if ((sum8 !== exp_v[8:0]) || (ovf8 !== exp_v[33]))
            $display("FAIL bp_result %0d: got sum %h ovf %b want sum %h ovf %b", got, sum8, ovf8, exp_v[8:0], exp_v[33]);
          else n_pass++;
        end
        got++;
      end
      if (iv8 && ir8) begin
        q8.push_back({eo[3-sent], 24'd0, ev[3-sent]});
        sent++;
      end
    end
    or8 = 1'b1;
    n_checks++;
    if ((got != 4) || (q8.size() != 0) || !seen)
      $display("FAIL bp_count: got %0d results, %0d pending, want 4 and 0", got, q8.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int  acc_it = -100;
    logic seen  = 1'b0;
    @(negedge clk);
    or8 = 1'b1; iv8 = 1'b1; a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
    #1;
    n_checks++;
    if (ir8 !== 1'b1) $display("FAIL rmid_accept: in_ready %b want 1", ir8);
    else n_pass++;
    // Reset on the next edge, with a competing handshake that must lose.
    @(negedge clk);
    rst = 1'b1; a8 = 8'h55; b8 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst = 1'b0; iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      end
      #1;
      n_checks++;
      if (ov8 !== 1'b0) $display("FAIL rmid_flushed cycle %0d: out_valid %b sum %h want 0", i, ov8, sum8);
      else n_pass++;
    end
    for (int it = 0; it < 6; it++) begin
      @(negedge clk);
      if (it == 0) begin
        iv8 = 1'b1; a8 = 8'h33; b8 = 8'h44;
      end else begin
        iv8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      end
      #1;
      if (iv8 && ir8) acc_it = it;
      if (ov8) begin
        n_checks++;
        if (seen) $display("FAIL rmid_duplicate: got sum %h want no second result", sum8);
        else if ((sum8 !== 9'h077) || (ovf8 !== 1'b0) || (it != acc_it + LAT8))
          $display("FAIL rmid_after: got sum %h ovf %b cycle %0d want sum 077 ovf 0 cycle %0d", sum8, ovf8, it, acc_it + LAT8);
        else n_pass++;
        seen = 1'b1;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL rmid_missing: got no result want 077");
    else n_pass++;
  endtask

  task automatic test_random8(input int n);
    logic [33:0] exp_v;
    int sent = 0;
    for (int it = 0; it < 10000 && (sent < n || q8.size() > 0); it++) begin
      @(negedge clk);
      iv8  = (sent < n) && ($urandom_range(0, 3) != 0);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      sub8 = 1'($urandom);
      or8  = ($urandom_range(0, 3) != 0);
      #1;
      if (ov8 && or8) begin
        n_checks++;
        if (q8.size() == 0) $display("FAIL rand8_extra: got sum %h want none", sum8);
        else begin
          exp_v = q8.pop_front();
          if ((sum8 !== exp_v[8:0]) || (ovf8 !== exp_v[33]))
            $display("FAIL rand8: got sum %h ovf %b want sum %h ovf %b", sum8, ovf8, exp_v[8:0], exp_v[33]);
          else n_pass++;
        end
      end
      if (iv8 && ir8) begin
        q8.push_back(ref_model(8, {24'd0, a8}, {24'd0, b8}, sub8));
        sent++;
      end
    end
    iv8 = 1'b0; or8 = 1'b1;
    n_checks++;
    if ((sent != n) || (q8.size() != 0)) $display("FAIL rand8_drain: sent %0d pending %0d want %0d and 0", sent, q8.size(), n);
    else n_pass++;
  endtask

  task automatic test_random32(input int n);
    logic [33:0] exp_v;
    int sent = 0;
    for (int it = 0; it < 10000 && (sent < n || q32.size() > 0); it++) begin
      @(negedge clk);
      iv32  = (sent < n) && ($urandom_range(0, 3) != 0);
      a32   = $urandom;
      b32   = $urandom;
      // Bias toward sign-boundary operands so overflow is exercised often.
      if ($urandom_range(0, 3) == 0) a32 = {a32[31], 31'h7FFF_FFFF};
      sub32 = 1'($urandom);
      or32  = ($urandom_range(0, 3) != 0);
      #1;
      if (ov32 && or32) begin
        n_checks++;
        if (q32.size() == 0) $display("FAIL rand32_extra: got sum %h want none", sum32);
        else begin
          exp_v = q32.pop_front();
          if ((sum32 !== exp_v[32:0]) || (ovf32 !== exp_v[33]))
            $display("FAIL rand32: got sum %h ovf %b want sum %h ovf %b", sum32, ovf32, exp_v[32:0], exp_v[33]);
          else n_pass++;
        end
      end
      if (iv32 && ir32) begin
        q32.push_back(ref_model(32, a32, b32, sub32));
        sent++;
      end
    end
    iv32 = 1'b0; or32 = 1'b1;
    n_checks++;
    if ((sent != n) || (q32.size() != 0)) $display("FAIL rand32_drain: sent %0d pending %0d want %0d and 0", sent, q32.size(), n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arith_seq("carry_ovf", 1'b0, {8'hFF, 8'h7F, 8'h80}, {8'h01, 8'h01, 8'h80},
                   {9'h100, 9'h080, 9'h100}, 3'b011);
    test_arith_seq("subtract", 1'b1, {8'h05, 8'h07, 8'h80}, {8'h07, 8'h05, 8'h01},
                   {9'h0FE, 9'h102, 9'h17F}, 3'b001);
    test_backpressure();
    test_reset_mid();
    test_random8(1500);
    test_random32(1000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
